// File: rtl/shift_register_load_ctrl.sv
// Loading engine for an external enable-gated serial-in shift register (MSB-first, entry at Q[0]).
// Optional readback compare of the loaded field is built when SHIFT_LOAD_VERIFY_EN is defined.
module shift_register_load_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WIDTH-1:0]           req_word,
    input  logic [$clog2(WIDTH):0]     req_len,
    input  logic                       stall,
    output logic                       sr_en,
    output logic                       sr_d,
    input  logic [WIDTH-1:0]           sr_q,
    output logic                       done_valid,
    input  logic                       done_ready,
    output logic [WIDTH-1:0]           done_word,
    output logic                       busy,
    output logic                       mismatch
);

    localparam int IW = $clog2(WIDTH);
    localparam int LW = IW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] done_word_q;
    logic [LW-1:0]    eff_len;

    // Zero and oversized lengths both mean a full-width load.
    always_comb begin
        eff_len = req_len;
        if (req_len == '0 || req_len > LW'(WIDTH)) begin
            eff_len = LW'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        sr_en      = 1'b0;
        sr_d       = 1'b0;
        done_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_en = !stall;
                sr_d  = word_q[idx_q];
                if (!stall && idx_q == '0) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // idx walks from L-1 down to 0 so the field leaves MSB-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            idx_q       <= '0;
            done_word_q <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                word_q <= req_word;
                idx_q  <= IW'(eff_len - LW'(1));
            end else if (state_q == SHIFT && !stall) begin
                idx_q <= idx_q - IW'(1);
            end
            if (state_q == CAPTURE) begin
                done_word_q <= sr_q;
            end
        end
    end

    assign done_word = done_word_q;

`ifdef SHIFT_LOAD_VERIFY_EN
    logic [LW-1:0]    len_q;
    logic [WIDTH-1:0] len_mask;
    logic             mismatch_q;

    assign len_mask = {WIDTH{1'b1}} >> (LW'(WIDTH) - len_q);

    // Only the freshly loaded low L bits are compared; upper bits are old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                len_q <= eff_len;
            end
            if (state_q == CAPTURE) begin
                mismatch_q <= |((sr_q ^ word_q) & len_mask);
            end else if (state_q == DONE && done_ready) begin
                mismatch_q <= 1'b0;
            end
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_load_ctrl.sv
// Bench for shift_register_load_ctrl: models the external shift register and predicts
// each completion from word/length arithmetic; honours SHIFT_LOAD_VERIFY_EN for mismatch.
module tb_shift_register_load_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          stall = 1'b0;
    logic          done_ready = 1'b0;
    logic [W-1:0]  req_word = '0;
    logic [5:0]    req_len = '0;
    logic          req_ready, sr_en, sr_d, done_valid, busy, mismatch;
    logic [W-1:0]  sr_q, done_word;

    logic [W-1:0]  ext_reg;
    logic [W-1:0]  force_mask = '0;
    logic          clear_ext = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    shift_register_load_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_word(req_word), .req_len(req_len),
        .stall(stall), .sr_en(sr_en), .sr_d(sr_d), .sr_q(sr_q),
        .done_valid(done_valid), .done_ready(done_ready), .done_word(done_word),
        .busy(busy), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // External register: shifts toward the MSB on enable; force_mask models stuck-at-0 outputs.
    always @(posedge clk) begin
        if (clear_ext) ext_reg <= '0;
        else if (sr_en) ext_reg <= {ext_reg[W-2:0], sr_d};
    end
    assign sr_q = ext_reg & ~force_mask;

    task automatic preclear();
        clear_ext = 1'b1;
        @(negedge clk);
        clear_ext = 1'b0;
    endtask

    // Must be called at a negedge; returns at a negedge with the block idle again.
    task automatic do_txn(input logic [W-1:0] word, input logic [5:0] len, input int stall_at,
                          input int stall_n, input int hold_n, input bit keep);
        int l, cyc, shifts, stall_left, stall_total, waitc;
        bit done_seen, applied;
        logic [63:0] mask, wide;
        logic [W-1:0] snap, exp_word;
        logic exp_mm;
        l = (int'(len) == 0 || int'(len) > W) ? W : int'(len);
        mask = (64'd1 << l) - 64'd1;
        req_valid = 1'b1; req_word = word; req_len = len; done_ready = 1'b0; stall = 1'b0;
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (req_ready !== 1'b1) $display("[TB] FAIL accept_wait: req_ready got %b required 1", req_ready);
        else n_pass++;
        snap = ext_reg;
        wide = ({32'd0, snap} << l) | ({32'd0, word} & mask);
        exp_word = wide[W-1:0] & ~force_mask;
`ifdef SHIFT_LOAD_VERIFY_EN
        exp_mm = |((exp_word ^ word) & mask[W-1:0]);
`else
        exp_mm = 1'b0;
`endif
        @(posedge clk);
        cyc = 0; shifts = 0; stall_left = 0; stall_total = 0; done_seen = 0; applied = 0;
        while (!done_seen && cyc < 120) begin
            @(negedge clk);
            cyc++;
            if (!keep) req_valid = 1'b0;
            if (sr_en === 1'b1) begin
                n_checks++;
                if (shifts >= l) $display("[TB] FAIL extra_shift: shift %0d beyond length %0d", shifts + 1, l);
                else if (sr_d !== word[l-1-shifts]) $display("[TB] FAIL sr_d: bit %0d got %b required %b", l-1-shifts, sr_d, word[l-1-shifts]);
                else n_pass++;
                shifts++;
            end
            if (stall) begin
                n_checks++;
                if (sr_en !== 1'b0) $display("[TB] FAIL stall_gate: sr_en got %b required 0", sr_en);
                else n_pass++;
            end
            if (done_valid === 1'b1) begin
                done_seen = 1;
                n_checks++;
                if (cyc != l + 2 + stall_total) $display("[TB] FAIL latency: done_valid at accept+%0d required accept+%0d", cyc, l + 2 + stall_total);
                else n_pass++;
                n_checks++;
                if (shifts != l) $display("[TB] FAIL shift_count: got %0d required %0d", shifts, l);
                else n_pass++;
                n_checks++;
                if (done_word !== exp_word) $display("[TB] FAIL done_word: got %h required %h", done_word, exp_word);
                else n_pass++;
                n_checks++;
                if (mismatch !== exp_mm) $display("[TB] FAIL mismatch: got %b required %b", mismatch, exp_mm);
                else n_pass++;
                if (hold_n == 0) done_ready = 1'b1;
            end else begin
                n_checks++;
                if ({req_ready, busy} !== 2'b01) $display("[TB] FAIL busy_phase: req_ready,busy got %b required 01", {req_ready, busy});
                else n_pass++;
            end
            stall = 1'b0;
            if (stall_left > 0) begin
                stall = 1'b1; stall_left--; stall_total++;
            end else if (!applied && stall_n > 0 && shifts == stall_at) begin
                applied = 1; stall = 1'b1; stall_left = stall_n - 1; stall_total++;
            end
        end
        stall = 1'b0;
        n_checks++;
        if (!done_seen) begin
            $display("[TB] FAIL done_timeout: done_valid got 0 required 1 within %0d cycles", cyc);
            return;
        end
        n_pass++;
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            n_checks++;
            if ({done_valid, req_ready} !== 2'b10 || done_word !== exp_word || mismatch !== exp_mm)
                $display("[TB] FAIL done_hold: valid,ready,word,mm got %b%b %h %b required 10 %h %b",
                         done_valid, req_ready, done_word, mismatch, exp_word, exp_mm);
            else n_pass++;
            if (h == hold_n - 1) done_ready = 1'b1;
        end
        @(negedge clk);
        done_ready = 1'b0;
        n_checks++;
        if ({done_valid, req_ready, busy, mismatch} !== 4'b0100)
            $display("[TB] FAIL post_handshake: valid,ready,busy,mm got %b required 0100", {done_valid, req_ready, busy, mismatch});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, sr_en, sr_d, done_valid, busy, mismatch} !== 6'b100000)
            $display("[TB] FAIL reset_ctrl: ready,en,d,valid,busy,mm got %b required 100000",
                     {req_ready, sr_en, sr_d, done_valid, busy, mismatch});
        else n_pass++;
        n_checks++;
        if (done_word !== '0) $display("[TB] FAIL reset_word: got %h required 0", done_word);
        else n_pass++;
        @(negedge clk);
        preclear();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        do_txn(32'hA5A50F0F, 6'd0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_short_word();
        preclear();
        do_txn(32'h000000C3, 6'd8, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        do_txn(32'h3C96E1A7, 6'd32, 10, 3, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn(32'h12345678, 6'd12, 0, 0, 5, 1'b1);
        do_txn(32'h12345678, 6'd12, 0, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        int shifts, cyc;
        bit spurious;
        preclear();
        req_valid = 1'b1; req_word = 32'hDEADBEEF; req_len = 6'd32;
        @(posedge clk);
        shifts = 0; cyc = 0;
        while (shifts < 10 && cyc < 40) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (sr_en === 1'b1) shifts++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sr_en, busy, done_valid, req_ready} !== 4'b0001)
            $display("[TB] FAIL abort_async: en,busy,valid,ready got %b required 0001", {sr_en, busy, done_valid, req_ready});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_valid !== 1'b0 || busy !== 1'b0) spurious = 1;
        end
        n_checks++;
        if (spurious) $display("[TB] FAIL abort_silent: completion or busy seen got 1 required 0");
        else n_pass++;
        do_txn(32'h0F1E2D3C, 6'd20, 0, 0, 1, 1'b0);
    endtask

    task automatic test_mismatch();
        preclear();
        force_mask = 32'h00000010;
        do_txn(32'hFFFFFFFF, 6'd32, 0, 0, 2, 1'b0);
        force_mask = '0;
    endtask

    task automatic test_random();
        logic [W-1:0] word;
        logic [5:0] len;
        int l, sat, sn;
        for (int t = 0; t < 25; t++) begin
            word = $urandom;
            len = 6'($urandom_range(0, 63));
            l = (int'(len) == 0 || int'(len) > W) ? W : int'(len);
            sat = 0; sn = 0;
            if (l >= 2 && $urandom_range(0, 1) == 1) begin
                sat = $urandom_range(1, l - 1);
                sn = $urandom_range(1, 3);
            end
            force_mask = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : '0;
            if ($urandom_range(0, 2) == 0) preclear();
            do_txn(word, len, sat, sn, $urandom_range(0, 3), 1'b0);
        end
        force_mask = '0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_word();
        test_stall();
        test_back_to_back();
        test_abort();
        test_mismatch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_register_load_ctrl.md
# shift_register_load_ctrl

Sequencer that serially loads a word into an external enable-gated serial-in shift register. Bit entry is Q[0] and shifts toward Q[WIDTH-1]. Accepts a word and bit count over a valid/ready request port, drives the register's enable and serial data for exactly that many non-stalled cycles, then snapshots the parallel output and returns it over a valid/ready completion port. Sits beside the FP32 datapath's shift registers as their loading engine.

## Interface
- WIDTH, 32: shift register width; bit counter is $clog2(WIDTH)+1 bits wide.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_word  in  WIDTH  word to load.
- req_len  in  $clog2(WIDTH)+1  bits to shift; 0 means WIDTH; values >WIDTH are clamped to WIDTH.
- stall  in  1  freeze shifting for this cycle.
- sr_en  out  1  shift enable to external register.
- sr_d  out  1  serial data to external register.
- sr_q  in  WIDTH  parallel output of external register.
- done_valid  out  1  completion present.
- done_ready  in  1  consumer accepts completion.
- done_word  out  WIDTH  snapshot of sr_q.
- busy  out  1  high in any state except IDLE.
- mismatch  out  1  readback mismatch flag, qualified by done_valid.

## Operation
- States: IDLE, SHIFT, CAPTURE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register req_word and effective length L (1..WIDTH).
  - Set bit index idx=L-1 and go to SHIFT.
- SHIFT:
  - sr_d=word[idx], sr_en=!stall (combinational on stall).
  - Each cycle with stall=0: the shift occurs and idx decrements.
  - Shift with idx==0 → CAPTURE.
  - Bits are sent MSB-first of the L-bit field, so after L shifts sr_q[L-1:0]==word[L-1:0]. Upper bits hold prior contents shifted up.
- CAPTURE:
  - sr_en=0.
  - Register done_word<=sr_q, plus mismatch (see Configuration).
  - Always → DONE.
- DONE:
  - done_valid=1; done_word and mismatch held stable.
  - On done_ready → IDLE.
- req_ready=0 outside IDLE; req_valid there is ignored, not queued.
- stall is ignored outside SHIFT. done_ready is ignored outside DONE.
- No overlap: a new request can only be accepted the cycle after the completion handshake.

## Timing
- Reset values: state IDLE, req_ready=1, sr_en=0, sr_d=0, done_valid=0, done_word=0, mismatch=0, busy=0.
- sr_en, sr_d, req_ready, done_valid and busy are decoded from registered state, except that sr_en is also gated by stall.
- Accept at rising edge ending cycle N → SHIFT from cycle N+1.
- With no stall:
  - sr_en high in cycles N+1..N+L.
  - CAPTURE in cycle N+L+1.
  - done_valid high from cycle N+L+2.
- Each stalled SHIFT cycle adds one cycle of latency.
- Completion handshake at edge ending cycle M → IDLE in M+1, with req_ready=1 in M+1.
- Best-case request-to-request period is L+3 cycles.
- rst_n low at any time:
  - Immediate return to IDLE; all outputs go to reset values asynchronously. sr_en drops in the same cycle.
  - The external register contents are its own concern.
  - A request in flight is discarded; no done_valid is produced for it.

## Configuration
- SHIFT_LOAD_VERIFY_EN defined:
  - In CAPTURE, mismatch<=(sr_q[L-1:0]!=word[L-1:0]).
  - mismatch is held through DONE and cleared on the completion handshake.
- Not defined: compare logic is absent and mismatch is tied 0. All other behaviour is identical.

## Test plan
- Reset, then req_word=0xA5A50F0F, req_len=0, stall=0, done_ready=1:
  - sr_en high exactly 32 cycles, with sr_d sequence = bits 31 down to 0.
  - done_valid at accept+34 for one cycle; done_word=0xA5A50F0F; mismatch=0.
- Register pre-cleared, req_word=0x000000C3, req_len=8:
  - 8 shifts, sr_d sequence 1,1,0,0,0,0,1,1.
  - done_word=0x000000C3; done_valid at accept+10.
- req_len=32, stall high for 3 cycles after the 10th shift:
  - sr_en low those 3 cycles and idx frozen.
  - done_valid at accept+37; done_word equals the word.
- done_ready held low 5 cycles in DONE, req_valid high throughout:
  - done_valid and done_word stable, req_ready=0, no new accept.
  - After the handshake, req_ready=1 next cycle and the pending request is accepted.
- rst_n pulsed low after 10 shifts:
  - sr_en, busy and done_valid go 0 immediately; req_ready=1; no completion for the aborted request.
  - The next request completes normally.
- Macro defined, sr_q bit 4 forced 0, word 0xFFFFFFFF, len 32: mismatch=1 with done_valid.
- Same stimulus, macro undefined: mismatch=0.
